// File: rtl/iob_csr_bank_pkg.sv
// Register map, CTRL field positions, reset values and the byte-strobe merge helper shared by the CSR bank.
package iob_csr_bank_pkg;

    localparam int CSR_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    // Word indices, i.e. addr[4:2]
    localparam logic [2:0] REG_CTRL       = 3'd0;
    localparam logic [2:0] REG_STATUS     = 3'd1;
    localparam logic [2:0] REG_SCRATCH    = 3'd2;
    localparam logic [2:0] REG_COUNT      = 3'd3;
    localparam logic [2:0] REG_IRQ_STATUS = 3'd4;
    localparam logic [2:0] REG_IRQ_MASK   = 3'd5;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;
    localparam int IRQ_W        = 8;

    // The clear bit is a strobe and is never stored
    localparam logic [CSR_W-1:0] CTRL_WMASK  = 32'hFFFF_FFFD;
    localparam logic [CSR_W-1:0] CTRL_RST    = 32'h0000_0000;
    localparam logic [CSR_W-1:0] SCRATCH_RST = 32'h0000_0000;
    localparam logic [IRQ_W-1:0] IRQ_RST     = 8'h00;

    function automatic logic [CSR_W-1:0] apply_wstrb(input logic [CSR_W-1:0]   cur,
                                                     input logic [CSR_W-1:0]   wd,
                                                     input logic [CSR_W/8-1:0] be);
        logic [CSR_W-1:0] res;
        res = cur;
        for (int b = 0; b < CSR_W/8; b++) begin
            if (be[b]) res[b*8 +: 8] = wd[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/iob_csr_bank_counter.sv
// Free-running cycle counter with synchronous clear (clear beats increment) and a wrap pulse.
module iob_csr_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic [W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        wrap    = 1'b0;
        if (clr) begin
            value_d = '0;
        end else if (en) begin
            value_d = value_q + W'(1);
            wrap    = &value_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) value_q <= '0;
        else     value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/iob_csr_bank.sv
// Native-bus CSR bank: CTRL, STATUS, SCRATCH, COUNT and, with IOB_CSR_BANK_IRQ_EN defined,
// IRQ_STATUS/IRQ_MASK plus the irq output. One-cycle registered response per request.
module iob_csr_bank
    import iob_csr_bank_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic [DATA_W-1:0]   ctrl,
    input  logic [DATA_W-1:0]   status,
    input  logic [6:0]          events
`ifdef IOB_CSR_BANK_IRQ_EN
    ,
    output logic                irq
`endif
);

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   scratch_q, scratch_d;
    logic [DATA_W-1:0]   count;
    logic                wrap;
    logic                req, wr, cnt_clr;
    logic [2:0]          idx;

`ifdef IOB_CSR_BANK_IRQ_EN
    logic [IRQ_W-1:0]    irq_status_q, irq_status_d;
    logic [IRQ_W-1:0]    irq_mask_q, irq_mask_d;
    logic                irq_q, irq_d;
`endif

    assign req     = (state_q == ST_IDLE) && valid;
    assign wr      = req && (|wstrb);
    assign idx     = addr[4:2];
    assign cnt_clr = wr && (idx == REG_CTRL) && wstrb[0] && wdata[CTRL_CLR_BIT];

    iob_csr_counter #(.W(DATA_W)) u_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl_q[CTRL_EN_BIT]),
        .clr   (cnt_clr),
        .value (count),
        .wrap  (wrap)
    );

    always_comb begin
        state_d   = (state_q == ST_IDLE && valid) ? ST_RESP : ST_IDLE;
        ready_d   = req;
        rdata_d   = '0;
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
`ifdef IOB_CSR_BANK_IRQ_EN
        irq_mask_d   = irq_mask_q;
        irq_status_d = irq_status_q;
        irq_d        = |(irq_status_q & irq_mask_q);
        if (wr && idx == REG_IRQ_STATUS && wstrb[0]) irq_status_d = irq_status_q & ~wdata[IRQ_W-1:0];
        // Hardware set is applied last so it wins over a same-cycle W1C
        irq_status_d = irq_status_d | {events, wrap};
`endif
        if (wr) begin
            case (idx)
                REG_CTRL:    ctrl_d    = apply_wstrb(ctrl_q, wdata, wstrb) & CTRL_WMASK;
                REG_SCRATCH: scratch_d = apply_wstrb(scratch_q, wdata, wstrb);
`ifdef IOB_CSR_BANK_IRQ_EN
                REG_IRQ_MASK: if (wstrb[0]) irq_mask_d = wdata[IRQ_W-1:0];
`endif
                default: ;
            endcase
        end else if (req) begin
            case (idx)
                REG_CTRL:    rdata_d = ctrl_q;
                REG_STATUS:  rdata_d = status;
                REG_SCRATCH: rdata_d = scratch_q;
                REG_COUNT:   rdata_d = count;
`ifdef IOB_CSR_BANK_IRQ_EN
                REG_IRQ_STATUS: rdata_d = {24'd0, irq_status_q};
                REG_IRQ_MASK:   rdata_d = {24'd0, irq_mask_q};
`endif
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            ctrl_q    <= CTRL_RST;
            scratch_q <= SCRATCH_RST;
`ifdef IOB_CSR_BANK_IRQ_EN
            irq_status_q <= IRQ_RST;
            irq_mask_q   <= IRQ_RST;
            irq_q        <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
`ifdef IOB_CSR_BANK_IRQ_EN
            irq_status_q <= irq_status_d;
            irq_mask_q   <= irq_mask_d;
            irq_q        <= irq_d;
`endif
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign ctrl  = ctrl_q;

`ifdef IOB_CSR_BANK_IRQ_EN
    assign irq = irq_q;
    logic unused_sigs;
    assign unused_sigs = ^{addr[ADDR_W-1:5], addr[1:0]};
`else
    logic unused_sigs;
    assign unused_sigs = ^{addr[ADDR_W-1:5], addr[1:0], events, wrap};
`endif

endmodule
